pmem_write_buffer: RTL and testbench
====================================

# pmem_write_buffer

Write-back buffer between the shared L1 arbiter's C port and physical memory. Absorbs full-line writes (L1 evictions) into a small FIFO, acknowledges them without waiting for memory, and drains them to physical memory when no read is pending. Reads are served from the buffer on a line hit; otherwise they go to physical memory ahead of any queued drain.

## Interface
- DEPTH, 4, number of line entries; power of two, at least 2.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- arb_read  in  1  read request from arbiter; held until arb_resp.
- arb_write  in  1  write request from arbiter; held until arb_resp; never asserted together with arb_read.
- arb_address  in  16  (lc3b_word) byte address; line = arb_address[15:4].
- arb_wdata  in  128  (l1_cache_line) full line to write.
- arb_rdata  out  128  read line; valid only while arb_resp is high.
- arb_resp  out  1  one-cycle completion pulse.
- pmem_read  out  1  physical memory read strobe; held until pmem_resp.
- pmem_write  out  1  physical memory write strobe; held until pmem_resp.
- pmem_address  out  16  line-aligned address, {line, 4'b0}.
- pmem_wdata  out  128  line being drained.
- pmem_rdata  in  128  memory read data; valid with pmem_resp.
- pmem_resp  in  1  memory completion pulse.

## Operation
- Storage: circular FIFO of DEPTH entries, each holding {valid, line[11:0], data[127:0]}.
  - head and tail pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - count is $clog2(DEPTH)+1 bits wide.
- FSM states: IDLE, RD_MEM, DRAIN, RESPOND, GAP.
- IDLE:
  - Read, line hits a valid entry: latch that entry's data, go to RESPOND.
  - Read, line misses: latch the line-aligned address, go to RD_MEM.
  - Write, line matches a valid entry that is not the head in flight: overwrite that entry's data (merge, count unchanged), go to RESPOND.
  - Write, no match and count < DEPTH: write the entry at tail, advance tail, count+1, go to RESPOND.
  - Write, no match and count == DEPTH: stay in IDLE with no response. The drain branch below runs.
  - No request, or a stalled full write, with count > 0: go to DRAIN on the head entry.
  - Priority order: read > write > drain.
- RD_MEM: hold pmem_read. On pmem_resp, latch pmem_rdata and go to RESPOND.
- DRAIN: hold pmem_write with the head entry's address and data. On pmem_resp, clear the head's valid bit, advance head, count-1, go to IDLE. A drain is never aborted.
- RESPOND: drive arb_resp=1 and arb_rdata (the latched line on reads, don't-care on writes). Go to GAP.
- GAP: ignore arb_read and arb_write for one cycle, then go to IDLE. The requester deasserts within this cycle.
- Read-hit rule: if two entries match the line (only possible when the head is in flight), return the youngest. Because merge removes other duplicates, this case is rare.
- Read/drain collision: a read that arrives while in DRAIN waits until the drain completes, then is decoded in IDLE. It hits the buffer if its entry is still present.
- Reset: clear all valid bits, head=tail=count=0, FSM to IDLE. An in-flight pmem transaction is abandoned.

## Timing
- Reset values: arb_resp=0, arb_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0. All take effect on the first edge with reset high.
- All outputs are registered or decoded from state only. There is no combinational path from arb_* or pmem_* inputs to any output.
- Write accept or read hit: request sampled in IDLE at cycle N gives arb_resp at N+1.
- Read miss: request in IDLE at cycle N gives pmem_read high from N+1. If pmem_resp arrives at cycle M, arb_resp is high at M+1.
- Drain: pmem_write rises the cycle after the IDLE decision.
- Minimum request-to-request spacing: 3 cycles (IDLE, RESPOND, GAP).

## Structure
- lc3b_types: reuse lc3b_word and l1_cache_line.
  - Add wb_line (12-bit line tag).
  - Add a wb_state enum.
- Sub-module write_buffer_storage: entry array, head/tail/count, a per-entry match vector, a youngest-match select, and enqueue/merge/pop ports.
- FSM lives in pmem_write_buffer.

## Test plan
- Reset, then idle: all outputs are 0. No pmem strobe while the buffer is empty.
- Write 0x1230 data A with memory stalled: arb_resp at N+1. Then pmem_write with pmem_address=0x1230 and pmem_wdata=A. After pmem_resp, count=0.
- Write 0x1230=A, then read 0x1238 before the drain starts: hit, arb_rdata=A one cycle after the request, no pmem_read.
- Write 0x2000=A, then write 0x2000=B while memory is busy with another line: entries merge, and exactly one pmem_write with B is issued.
- Fill 4 entries (0x0000, 0x0010, 0x0020, 0x0030), then write 0x0040: no arb_resp until the drain of 0x0000 completes. Then 0x0040 is accepted, and tail wraps to 0.
- With 2 entries queued, read a miss at 0x4000 with pmem_resp at a 5-cycle delay: pmem_read is issued before any pmem_write, and arb_rdata=pmem_rdata. Assert reset during a later drain: the FSM returns to IDLE and count=0.

Source files
------------

// File: rtl/pmem_write_buffer_pkg.sv
// Shared types for the L1-to-physical-memory write-back buffer.
package pmem_write_buffer_pkg;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] l1_cache_line;
   typedef logic [11:0]  wb_line;

   typedef enum logic [2:0] {
      WB_IDLE    = 3'd0,
      WB_RD_MEM  = 3'd1,
      WB_DRAIN   = 3'd2,
      WB_RESPOND = 3'd3,
      WB_GAP     = 3'd4
   } wb_state;

   function automatic lc3b_word line_addr(input wb_line line);
      return {line, 4'b0000};
   endfunction

endpackage

// File: rtl/pmem_write_buffer_storage.sv
// Circular FIFO of dirty lines with per-entry line match and youngest-hit select.
module pmem_write_buffer_storage
   import pmem_write_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  wb_line                     lookup_line_i,
   output logic                       hit_o,
   output logic [$clog2(DEPTH)-1:0]   hit_idx_o,
   output l1_cache_line               hit_data_o,
   input  logic                       enq_i,
   input  wb_line                     enq_line_i,
   input  logic                       merge_i,
   input  logic [$clog2(DEPTH)-1:0]   merge_idx_i,
   input  l1_cache_line               wdata_i,
   input  logic                       pop_i,
   output wb_line                     head_line_o,
   output l1_cache_line               head_data_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o
);

   localparam int PW = $clog2(DEPTH);

   logic [DEPTH-1:0] valid_q;
   wb_line           line_q [DEPTH];
   l1_cache_line     data_q [DEPTH];
   logic [PW-1:0]    head_q;
   logic [PW-1:0]    tail_q;
   logic [PW:0]      count_q;
   logic [DEPTH-1:0] match;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (enq_i) begin
            valid_q[tail_q] <= 1'b1;
            tail_q          <= tail_q + 1'b1;
         end
         if (pop_i) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + 1'b1;
         end
         case ({enq_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (enq_i) begin
         line_q[tail_q] <= enq_line_i;
         data_q[tail_q] <= wdata_i;
      end
      if (merge_i) begin
         data_q[merge_idx_i] <= wdata_i;
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         match[i] = valid_q[i] && (line_q[i] == lookup_line_i);
      end
   end

   // Walk from head towards tail so the last match seen is the youngest entry.
   always_comb begin
      logic [PW-1:0] idx;
      idx       = head_q;
      hit_o     = 1'b0;
      hit_idx_o = head_q;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PW'(k);
         if (match[idx]) begin
            hit_o     = 1'b1;
            hit_idx_o = idx;
         end
      end
   end

   assign hit_data_o  = data_q[hit_idx_o];
   assign head_line_o = line_q[head_q];
   assign head_data_o = data_q[head_q];
   assign count_o     = count_q;
   assign full_o      = count_q[PW];

endmodule

// File: rtl/pmem_write_buffer.sv
// Write-back buffer between the arbiter C port and physical memory: posts line
// writes, serves read hits locally, and drains to memory when no read waits.
module pmem_write_buffer
   import pmem_write_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    arb_read,
   input  logic                    arb_write,
   input  lc3b_word                arb_address,
   input  l1_cache_line            arb_wdata,
   output l1_cache_line            arb_rdata,
   output logic                    arb_resp,
   output logic                    pmem_read,
   output logic                    pmem_write,
   output lc3b_word                pmem_address,
   output l1_cache_line            pmem_wdata,
   input  l1_cache_line            pmem_rdata,
   input  logic                    pmem_resp,
   output wb_state                 dbg_state,
   output logic [$clog2(DEPTH):0]  dbg_count
);

   localparam int PW = $clog2(DEPTH);

   // Handshake: a requester holds arb_read/arb_write until the one-cycle arb_resp
   // and drops it during the following GAP cycle; pmem strobes are held by this
   // block until the one-cycle pmem_resp, after which they fall on the next edge.
   wb_state         state_q, state_d;
   logic            arb_resp_q;
   l1_cache_line    arb_rdata_q;
   logic            pmem_read_q;
   logic            pmem_write_q;
   lc3b_word        pmem_address_q;
   l1_cache_line    pmem_wdata_q;

   logic            hit;
   logic [PW-1:0]   hit_idx;
   l1_cache_line    hit_data;
   wb_line          head_line;
   l1_cache_line    head_data;
   logic [PW:0]     count;
   logic            full;
   logic            enq, merge, pop;
   wb_line          req_line;
   logic            addr_offset_unused;

   assign req_line           = arb_address[15:4];
   assign addr_offset_unused = ^arb_address[3:0];

   pmem_write_buffer_storage #(.DEPTH(DEPTH)) u_storage (
      .clk           (clk),
      .reset         (reset),
      .lookup_line_i (req_line),
      .hit_o         (hit),
      .hit_idx_o     (hit_idx),
      .hit_data_o    (hit_data),
      .enq_i         (enq),
      .enq_line_i    (req_line),
      .merge_i       (merge),
      .merge_idx_i   (hit_idx),
      .wdata_i       (arb_wdata),
      .pop_i         (pop),
      .head_line_o   (head_line),
      .head_data_o   (head_data),
      .count_o       (count),
      .full_o        (full)
   );

   // Writes are only decoded in IDLE, when no drain is in flight, so any match
   // is a legal merge target.
   always_comb begin
      state_d = state_q;
      enq     = 1'b0;
      merge   = 1'b0;
      pop     = 1'b0;
      case (state_q)
         WB_IDLE: begin
            if (arb_read) begin
               state_d = hit ? WB_RESPOND : WB_RD_MEM;
            end else if (arb_write && (hit || !full)) begin
               state_d = WB_RESPOND;
               merge   = hit;
               enq     = !hit;
            end else if (count != '0) begin
               state_d = WB_DRAIN;
            end
         end
         WB_RD_MEM:  if (pmem_resp) state_d = WB_RESPOND;
         WB_DRAIN: begin
            if (pmem_resp) begin
               pop     = 1'b1;
               state_d = WB_IDLE;
            end
         end
         WB_RESPOND: state_d = WB_GAP;
         WB_GAP:     state_d = WB_IDLE;
         default:    state_d = WB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= WB_IDLE;
         arb_resp_q     <= 1'b0;
         arb_rdata_q    <= '0;
         pmem_read_q    <= 1'b0;
         pmem_write_q   <= 1'b0;
         pmem_address_q <= '0;
         pmem_wdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         arb_resp_q   <= (state_d == WB_RESPOND);
         pmem_read_q  <= (state_d == WB_RD_MEM);
         pmem_write_q <= (state_d == WB_DRAIN);
         case (state_q)
            WB_IDLE: begin
               if (arb_read) begin
                  if (hit) arb_rdata_q    <= hit_data;
                  else     pmem_address_q <= line_addr(req_line);
               end else if (state_d == WB_DRAIN) begin
                  pmem_address_q <= line_addr(head_line);
                  pmem_wdata_q   <= head_data;
               end
            end
            WB_RD_MEM: if (pmem_resp) arb_rdata_q <= pmem_rdata;
            default: ;
         endcase
      end
   end

   assign arb_resp     = arb_resp_q;
   assign arb_rdata    = arb_rdata_q;
   assign pmem_read    = pmem_read_q;
   assign pmem_write   = pmem_write_q;
   assign pmem_address = pmem_address_q;
   assign pmem_wdata   = pmem_wdata_q;
   assign dbg_state    = state_q;
   assign dbg_count    = count;

endmodule

// File: tb/tb_pmem_write_buffer.sv
// Randomized and directed bench for pmem_write_buffer against a queue-based
// model of the posted-write buffer and a sparse backing memory.
module tb_pmem_write_buffer;
   import pmem_write_buffer_pkg::*;

   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         arb_read, arb_write;
   logic [15:0]  arb_address;
   logic [127:0] arb_wdata, arb_rdata;
   logic         arb_resp;
   logic         pmem_read, pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata, pmem_rdata;
   logic         pmem_resp;
   wb_state      dbg_state;
   logic [2:0]   dbg_count;

   int checks = 0;
   int errors = 0;

   logic [139:0] exp_q[$];               // posted lines, oldest first: {line, data}
   logic [127:0] mem_q [logic [11:0]];
   int           wr_per_line [logic [11:0]];
   int           op_log[$];              // 1 = memory read, 2 = memory write
   int           mem_lat = 1;
   bit           mem_hold = 1'b0;
   int           rd_issued = 0;
   int           wr_issued = 0;

   pmem_write_buffer #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .arb_read     (arb_read),
      .arb_write    (arb_write),
      .arb_address  (arb_address),
      .arb_wdata    (arb_wdata),
      .arb_rdata    (arb_rdata),
      .arb_resp     (arb_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp),
      .dbg_state    (dbg_state),
      .dbg_count    (dbg_count)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [127:0] mem_read(input logic [11:0] line);
      if (mem_q.exists(line)) return mem_q[line];
      return {8{4'hA, line}};
   endfunction

   function automatic int model_find(input logic [11:0] line);
      int r = -1;
      foreach (exp_q[i]) if (exp_q[i][139:128] == line) r = i;
      return r;
   endfunction

   task automatic model_write(input logic [11:0] line, input logic [127:0] data);
      int idx = model_find(line);
      if (idx >= 0) begin
         exp_q[idx] = {line, data};
      end else begin
         check("room_on_accept", 128'(exp_q.size() < DEPTH), 128'd1);
         exp_q.push_back({line, data});
      end
   endtask

   // ---------------- physical memory responder ----------------
   initial begin
      int wcnt = 0;
      bit seen = 1'b0;
      logic [139:0] e;
      logic [11:0] l;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (reset || pmem_resp) begin
            pmem_resp = 1'b0;
            wcnt = 0;
            seen = 1'b0;
         end else if (pmem_read || pmem_write) begin
            if (!seen) begin
               seen = 1'b1;
               op_log.push_back(pmem_read ? 1 : 2);
               check("pmem_one_strobe", 128'(pmem_read & pmem_write), 128'd0);
               check("pmem_addr_aligned", 128'(pmem_address[3:0]), 128'd0);
            end
            if (!mem_hold) wcnt++;
            if (wcnt >= mem_lat) begin
               l = pmem_address[15:4];
               if (pmem_read) begin
                  rd_issued++;
                  check("rd_only_on_miss", 128'(model_find(l) < 0), 128'd1);
                  pmem_rdata = mem_read(l);
               end else begin
                  wr_issued++;
                  if (wr_per_line.exists(l)) wr_per_line[l]++;
                  else wr_per_line[l] = 1;
                  check("drain_model_nonempty", 128'(exp_q.size() != 0), 128'd1);
                  if (exp_q.size() != 0) begin
                     e = exp_q.pop_front();
                     check("drain_addr", 128'(pmem_address), 128'({e[139:128], 4'h0}));
                     check("drain_data", pmem_wdata, e[127:0]);
                  end
                  mem_q[l] = pmem_wdata;
               end
               pmem_resp = 1'b1;
               wcnt = 0;
               seen = 1'b0;
            end
         end else begin
            wcnt = 0;
            seen = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      arb_read = 1'b0;
      arb_write = 1'b0;
      @(negedge clk);
      check("rst_arb_resp", 128'(arb_resp), 128'd0);
      check("rst_arb_rdata", arb_rdata, 128'd0);
      check("rst_pmem_read", 128'(pmem_read), 128'd0);
      check("rst_pmem_write", 128'(pmem_write), 128'd0);
      check("rst_pmem_address", 128'(pmem_address), 128'd0);
      check("rst_pmem_wdata", pmem_wdata, 128'd0);
      check("rst_state", 128'(dbg_state), 128'(WB_IDLE));
      check("rst_count", 128'(dbg_count), 128'd0);
      reset = 1'b0;
      exp_q.delete();
      op_log.delete();
   endtask

   task automatic do_req(input bit wr, input logic [15:0] addr, input logic [127:0] data,
                         output int lat);
      int idx;
      logic [127:0] exp_rd;
      @(negedge clk);
      check("resp_pulse_low", 128'(arb_resp), 128'd0);
      arb_read = !wr;
      arb_write = wr;
      arb_address = addr;
      arb_wdata = data;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!arb_resp && lat < 300);
      arb_read = 1'b0;
      arb_write = 1'b0;
      if (!arb_resp) begin
         check("resp_timeout", 128'd0, 128'd1);
         return;
      end
      if (wr) begin
         model_write(addr[15:4], data);
      end else begin
         idx = model_find(addr[15:4]);
         exp_rd = (idx >= 0) ? exp_q[idx][127:0] : mem_read(addr[15:4]);
         check("read_data", arb_rdata, exp_rd);
      end
      check("count_after_resp", 128'(dbg_count), 128'(exp_q.size()));
   endtask

   task automatic wait_empty();
      int n = 0;
      while (!(dbg_count == 0 && dbg_state == WB_IDLE && !pmem_write) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drained_count", 128'(dbg_count), 128'd0);
      check("model_empty", 128'(exp_q.size()), 128'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int lat, n, wr0, rd0;
      logic [127:0] a, b, c;
      reset = 1'b1;
      arb_read = 1'b0;
      arb_write = 1'b0;
      arb_address = '0;
      arb_wdata = '0;
      repeat (2) @(negedge clk);
      do_reset();

      repeat (5) begin
         @(negedge clk);
         check("idle_no_strobe", 128'({pmem_read, pmem_write}), 128'd0);
      end

      // Posted write with memory stalled, then its drain.
      mem_hold = 1'b1;
      mem_lat = 2;
      a = rand128();
      do_req(1'b1, 16'h1230, a, lat);
      check("wr_accept_lat", 128'(lat), 128'd1);
      n = 0;
      while (!pmem_write && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("drain_rise_lat", 128'(n), 128'd3);
      check("drain_addr_early", 128'(pmem_address), 128'h1230);
      check("drain_wdata_early", pmem_wdata, a);
      mem_hold = 1'b0;
      wait_empty();

      // Read hit before the drain starts; request raised in GAP is sampled one cycle later.
      rd0 = rd_issued;
      a = rand128();
      do_req(1'b1, 16'h1230, a, lat);
      do_req(1'b0, 16'h1238, '0, lat);
      check("rd_hit_lat", 128'(lat), 128'd2);
      check("rd_hit_no_pmem_read", 128'(rd_issued), 128'(rd0));
      wait_empty();

      // Merge into a queued entry while memory is busy with another line.
      wr_per_line.delete();
      mem_hold = 1'b1;
      a = rand128();
      b = rand128();
      c = rand128();
      do_req(1'b1, 16'h3000, c, lat);
      do_req(1'b1, 16'h2000, a, lat);
      repeat (3) @(negedge clk);
      fork
         do_req(1'b1, 16'h2000, b, lat);
         begin
            repeat (6) @(negedge clk);
            mem_hold = 1'b0;
         end
      join
      wait_empty();
      check("merge_single_drain", 128'(wr_per_line.exists(12'h200) ? wr_per_line[12'h200] : 0), 128'd1);

      // Fill all entries, then a fifth write stalls until the oldest drains.
      do_reset();
      mem_hold = 1'b1;
      for (int i = 0; i < 4; i++) do_req(1'b1, 16'(i * 16), rand128(), lat);
      check("tail_wrapped", 128'(dut.u_storage.tail_q), 128'd0);
      repeat (3) @(negedge clk);
      fork
         do_req(1'b1, 16'h0040, rand128(), lat);
         begin
            repeat (8) @(negedge clk);
            mem_hold = 1'b0;
         end
      join
      check("full_write_stalled", 128'(lat > 8), 128'd1);
      wait_empty();

      // Read miss takes priority over queued drains; then reset mid-drain.
      do_reset();
      mem_hold = 1'b0;
      mem_lat = 5;
      do_req(1'b1, 16'h5000, rand128(), lat);
      do_req(1'b1, 16'h5010, rand128(), lat);
      do_req(1'b0, 16'h4000, '0, lat);
      check("rd_miss_lat", 128'(lat), 128'd7);
      check("rd_before_drain", 128'(op_log.size() > 0 ? op_log[0] : 0), 128'd1);
      wr0 = wr_issued;
      n = 0;
      while (wr_issued == wr0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("first_drain_done", 128'(wr_issued - wr0), 128'd1);
      n = 0;
      while (!pmem_write && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("second_drain_started", 128'(pmem_write), 128'd1);
      mem_hold = 1'b1;
      repeat (2) @(negedge clk);
      do_reset();

      // Random traffic over a small line pool to exercise hits, merges and stalls.
      mem_hold = 1'b0;
      for (int it = 0; it < 80; it++) begin
         logic [15:0] addr;
         mem_lat = $urandom_range(1, 4);
         addr = {12'h600 + 12'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
         repeat ($urandom_range(0, 4)) @(negedge clk);
         do_req(($urandom_range(0, 2) != 0), addr, rand128(), lat);
      end
      wait_empty();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
